readout_frame_serializer: RTL

- Parametrised successor to the single-channel fast-readout path.
- A trigger snapshots CHANNELS parallel samples of DATA_W bits each.
- The block then emits them as one framed word stream: header, samples, XOR checksum. The stream uses a valid/ready handshake so downstream pin muxing can stall it.
- Sits between the sample front-end and the tt_um top-level output pins; triggers arriving mid-frame are counted as drops.

---
 rtl/readout_frame_serializer.sv | 100 ++++++++++
 1 files changed

// File: rtl/readout_frame_serializer.sv
// Snapshots CHANNELS samples on trigger and streams header, samples, XOR checksum.
// Latency: first word valid 1 cycle after trig; full rate 1 word/cycle; backpressure holds the word under valid/ready.
// Triggers that arrive while a frame is in flight are counted in a saturating drop counter.
module readout_frame_serializer #(
    parameter int                CHANNELS = 4,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] HEADER   = 8'hA5,
    parameter int                DROP_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         trig,
    input  logic [CHANNELS*DATA_W-1:0]   ch_data,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic [DROP_W-1:0]            drop_cnt
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, HEADER_S, DATA_S, CHECK_S} state_t;

    state_t                        state;
    logic [CHANNELS*DATA_W-1:0]    snap;
    logic [IDX_W-1:0]              idx;
    logic [DATA_W-1:0]             chk;
    logic                          accept;

    assign accept = out_valid && out_ready;

    always_comb begin
        chk = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            chk = chk ^ snap[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            // Every cycle with trig high outside IDLE is a rejected trigger.
            if (trig && state != IDLE && drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig && ena) begin
                        snap      <= ch_data;
                        state     <= HEADER_S;
                        out_data  <= HEADER;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                HEADER_S: begin
                    if (accept) begin
                        state    <= DATA_S;
                        idx      <= '0;
                        out_data <= snap[0 +: DATA_W];
                    end
                end
                DATA_S: begin
                    if (accept) begin
                        if (idx == IDX_W'(CHANNELS - 1)) begin
                            state    <= CHECK_S;
                            out_data <= chk;
                            out_last <= 1'b1;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_data <= snap[(int'(idx) + 1)*DATA_W +: DATA_W];
                        end
                    end
                end
                CHECK_S: begin
                    if (accept) begin
                        state     <= IDLE;
                        idx       <= '0;
                        out_data  <= '0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
